// File: rtl/morse_key_sequencer.sv
// Morse key sequencer: accepts ASCII characters, looks up their Huffman code through
// an external combinational translator, and plays the resulting dit/dah elements on a
// timed key output using standard Morse unit timing.
module morse_key_sequencer #(
    parameter int unsigned UNIT_CYCLES = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    output logic        char_ready,
    output logic [7:0]  lut_char,
    input  logic [15:0] lut_code,
    input  logic [4:0]  lut_len,
    output logic        key_out,
    output logic        busy,
    output logic        char_done,
    output logic        err_unsupported,
    output logic        err_malformed
);

    typedef enum logic [1:0] {StIdle, StLoad, StOn, StOff} state_e;
    typedef enum logic [2:0] {ElDit, ElDah, ElDelim, ElBad, ElNone} elem_e;

    // Phase counter reload values: units * UNIT_CYCLES - 1
    localparam logic [CNT_W-1:0] Cnt1 = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] Cnt3 = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] Cnt4 = CNT_W'(4 * UNIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [7:0]        lut_char_q, lut_char_d;
    logic [15:0]       shift_q, shift_d;
    logic [4:0]        rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;

    logic              len_bad;
    logic [15:0]       load_shift;
    logic [15:0]       par_shift;
    logic [4:0]        par_rem;
    elem_e             elem;
    logic              cnt_zero;

    state_e            start_state;
    logic [CNT_W-1:0]  start_cnt;
    logic [15:0]       start_shift;
    logic [4:0]        start_rem;
    logic              start_last;

    // Translator response decode and element parse on the current shift-register head
    always_comb begin
        len_bad    = (lut_len == 5'd0) || (lut_len > 5'd16);
        load_shift = lut_code << (5'd16 - lut_len);
        // In LOAD the freshly aligned code is parsed directly so there is no bubble cycle
        par_shift  = (state_q == StLoad) ? load_shift : shift_q;
        par_rem    = (state_q == StLoad) ? lut_len : rem_q;
        cnt_zero   = (cnt_q == '0);
        if (par_rem == 5'd0) begin
            elem = ElNone;
        end else if (!par_shift[15]) begin
            elem = ElDit;
        end else if (par_rem == 5'd1) begin
            elem = ElBad;
        end else if (par_shift[14]) begin
            elem = ElDelim;
        end else begin
            elem = ElDah;
        end
    end

    // Effect of starting the parsed element (used from LOAD and at the end of a gap)
    always_comb begin
        start_state = StIdle;
        start_cnt   = cnt_q;
        start_shift = par_shift;
        start_rem   = par_rem;
        start_last  = 1'b0;
        unique case (elem)
            ElDit: begin
                start_state = StOn;
                start_cnt   = Cnt1;
                start_shift = par_shift << 1;
                start_rem   = par_rem - 5'd1;
            end
            ElDah: begin
                start_state = StOn;
                start_cnt   = Cnt3;
                start_shift = par_shift << 2;
                start_rem   = par_rem - 5'd2;
            end
            ElDelim: begin
                // Space-only code: 4 units silent, completing a 7-unit word gap
                start_state = StOff;
                start_cnt   = Cnt4;
                start_shift = par_shift << 2;
                start_rem   = par_rem - 5'd2;
                start_last  = 1'b1;
            end
            default: begin
                start_state = StIdle;
            end
        endcase
    end

    // Next-state and datapath next-value logic
    always_comb begin
        state_d    = state_q;
        lut_char_d = lut_char_q;
        shift_d    = shift_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        unique case (state_q)
            StIdle: begin
                if (char_valid) begin
                    lut_char_d = char_in;
                    last_d     = 1'b0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                if (len_bad) begin
                    state_d = StIdle;
                end else begin
                    state_d = start_state;
                    cnt_d   = start_cnt;
                    shift_d = start_shift;
                    rem_d   = start_rem;
                    last_d  = start_last;
                end
            end
            StOn: begin
                if (cnt_zero) begin
                    // Peek ahead so the gap length already covers a letter gap
                    state_d = StOff;
                    if (elem == ElNone) begin
                        cnt_d  = Cnt1;
                        last_d = 1'b1;
                    end else if (elem == ElDelim) begin
                        cnt_d   = Cnt3;
                        last_d  = 1'b1;
                        shift_d = shift_q << 2;
                        rem_d   = rem_q - 5'd2;
                    end else begin
                        cnt_d  = Cnt1;
                        last_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StOff: begin
                if (cnt_zero) begin
                    if (last_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = start_state;
                        cnt_d   = start_cnt;
                        shift_d = start_shift;
                        rem_d   = start_rem;
                        last_d  = start_last;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: latched character, code shifter, bit count, phase counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_char_q <= 8'd0;
            shift_q    <= 16'd0;
            rem_q      <= 5'd0;
            cnt_q      <= '0;
            last_q     <= 1'b0;
        end else begin
            lut_char_q <= lut_char_d;
            shift_q    <= shift_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
        end
    end

    // Outputs decoded from state; ready is gated by reset so it drops immediately
    always_comb begin
        char_ready      = (state_q == StIdle) && rst_n;
        key_out         = (state_q == StOn);
        busy            = (state_q != StIdle);
        lut_char        = lut_char_q;
        err_unsupported = (state_q == StLoad) && len_bad;
        char_done       = (state_q == StOff) && cnt_zero && last_q;
        err_malformed   = (elem == ElBad) &&
                          (((state_q == StLoad) && !len_bad) ||
                           ((state_q == StOff) && cnt_zero && !last_q));
    end

endmodule

// File: tb/tb_morse_key_sequencer.sv
// Self-checking bench for morse_key_sequencer: a behavioural timing model turns each
// Huffman code into an expected per-cycle key/pulse timeline and the DUT is compared
// every cycle against it.
module tb_morse_key_sequencer;

    localparam int unsigned U = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  char_in = 8'd0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [7:0]  lut_char;
    logic [15:0] lut_code;
    logic [4:0]  lut_len;
    logic        key_out;
    logic        busy;
    logic        char_done;
    logic        err_unsupported;
    logic        err_malformed;

    logic [15:0] rnd_code = 16'd0;
    logic [4:0]  rnd_len = 5'd0;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       key;
        logic [1:0] ev;   // 0 none, 1 char_done, 2 err_unsupported, 3 err_malformed
    } step_t;

    step_t exp_q[$];

    morse_key_sequencer #(
        .UNIT_CYCLES(U),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .char_in(char_in),
        .char_valid(char_valid),
        .char_ready(char_ready),
        .lut_char(lut_char),
        .lut_code(lut_code),
        .lut_len(lut_len),
        .key_out(key_out),
        .busy(busy),
        .char_done(char_done),
        .err_unsupported(err_unsupported),
        .err_malformed(err_malformed)
    );

    always #5 clk = ~clk;

    // Translator stand-in: a few fixed characters, everything else uses the random slot
    function automatic logic [20:0] xlate(input logic [7:0] c, input logic [4:0] rl,
                                          input logic [15:0] rc);
        case (c)
            8'h45:   return {5'd3, 16'b011};      // E
            8'h41:   return {5'd5, 16'b01011};    // A
            8'h54:   return {5'd4, 16'b1011};     // T
            8'h20:   return {5'd2, 16'b11};       // space
            8'h23:   return {5'd0, 16'h0000};     // #
            8'h25:   return {5'd17, 16'h0003};    // %
            8'h21:   return {5'd3, 16'b001};      // ! malformed
            default: return {rl, rc};
        endcase
    endfunction

    always_comb {lut_len, lut_code} = xlate(lut_char, rnd_len, rnd_code);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_n(input logic key, input int n);
        step_t s;
        s.key = key;
        s.ev  = 2'd0;
        for (int k = 0; k < n; k++) exp_q.push_back(s);
    endtask

    task automatic set_ev(input logic [1:0] ev);
        exp_q[exp_q.size() - 1].ev = ev;
    endtask

    // Expected timeline from cycle N+1 (the lookup cycle) to the end of the character
    task automatic build(input logic [15:0] code, input int len);
        int   i;
        int   r;
        logic b0;
        logic b1;
        exp_q.delete();
        if (len == 0 || len > 16) begin
            push_n(1'b0, 1);
            set_ev(2'd2);
            return;
        end
        push_n(1'b0, 1);
        i = 0;
        forever begin
            r  = len - i;
            b0 = code[len - 1 - i];
            b1 = (r >= 2) ? code[len - 2 - i] : 1'b0;
            if (r >= 2 && b0 && b1) begin
                push_n(1'b0, 4 * U);
                set_ev(2'd1);
                return;
            end
            if (b0 && r == 1) begin
                set_ev(2'd3);
                return;
            end
            push_n(1'b1, b0 ? 3 * U : U);
            i += b0 ? 2 : 1;
            r = len - i;
            if (r == 0) begin
                push_n(1'b0, U);
                set_ev(2'd1);
                return;
            end
            b0 = code[len - 1 - i];
            b1 = (r >= 2) ? code[len - 2 - i] : 1'b0;
            if (r >= 2 && b0 && b1) begin
                push_n(1'b0, 3 * U);
                set_ev(2'd1);
                return;
            end
            push_n(1'b0, U);
        end
    endtask

    // Called right after the accepting edge; ends at the negedge of the next idle cycle
    task automatic expect_char(input logic [7:0] c);
        logic [20:0] t;
        logic [5:0]  obs;
        logic [5:0]  exp;
        t = xlate(c, rnd_len, rnd_code);
        build(t[15:0], int'(t[20:16]));
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge clk);
            if (k == 0) check($sformatf("lut_char %0h", c), 32'(lut_char), 32'(c));
            obs = {key_out, busy, char_ready, char_done, err_unsupported, err_malformed};
            exp = {exp_q[k].key, 1'b1, 1'b0, exp_q[k].ev == 2'd1, exp_q[k].ev == 2'd2,
                   exp_q[k].ev == 2'd3};
            check($sformatf("char %0h cyc %0d", c, k + 1), 32'(obs), 32'(exp));
        end
        @(negedge clk);
        obs = {key_out, busy, char_ready, char_done, err_unsupported, err_malformed};
        check($sformatf("char %0h back to idle", c), 32'(obs), 32'(6'b001000));
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        check($sformatf("ready before %0h", c), 32'(char_ready), 32'd1);
        char_in    = c;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        char_in    = 8'($urandom);
        expect_char(c);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #1;
        check("reset outputs", 32'({key_out, char_ready, busy, char_done, err_unsupported,
                                    err_malformed}), 32'd0);
        check("reset lut_char", 32'(lut_char), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready after release", 32'({char_ready, busy, key_out}), 32'(3'b100));

        // Directed characters
        send(8'h45);   // E
        send(8'h41);   // A
        send(8'h23);   // # unsupported, len 0
        send(8'h25);   // % unsupported, len 17
        send(8'h20);   // space
        send(8'h21);   // malformed 001

        // Held valid: T then E back-to-back
        @(negedge clk);
        char_in    = 8'h54;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_in = 8'h45;
        expect_char(8'h54);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        expect_char(8'h45);

        // Reset in the middle of a dah
        @(negedge clk);
        char_in    = 8'h54;
        char_valid = 1'b1;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("key high mid-dah", 32'(key_out), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset outputs", 32'({key_out, char_ready, busy, char_done,
                                          err_unsupported, err_malformed}), 32'd0);
        check("async reset lut_char", 32'(lut_char), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready after mid-char reset", 32'({char_ready, busy, key_out}), 32'(3'b100));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no pulse after abort", 32'({char_ready, busy, key_out, char_done,
                                               err_unsupported, err_malformed}),
                  32'(6'b100000));
        end
        send(8'h45);

        // Random codes and lengths through the translator's spare slot
        for (int k = 0; k < 40; k++) begin
            rnd_len  = 5'($urandom_range(0, 18));
            rnd_code = 16'($urandom);
            send(8'h80 + 8'(k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_key_sequencer.md
Name: morse_key_sequencer

Overview:
- Accepts ASCII characters over a valid/ready handshake and drives the combinational char-to-Huffman translator through its lookup ports.
- Latches the returned code and length, parses the code MSB-first into elements: dit = 0, dah = 10, delimiter = 11.
- Plays the elements on a timed key output using standard Morse unit timing.
- Sits between the text source (UART/keyboard front end) and the key/tone driver.

Parameters:
- UNIT_CYCLES, 16, clock cycles per Morse time unit; legal range is 1 or more.
- CNT_W, 16, width of the phase countdown counter; must hold 4*UNIT_CYCLES-1.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- char_in  in  8  ASCII character.
- char_valid  in  1  char_in is valid.
- char_ready  out  1  block can accept a character.
- lut_char  out  8  registered character presented to the translator.
- lut_code  in  16  translator Huffman code, right-aligned.
- lut_len  in  5  translator code length in bits; 0 means unsupported.
- key_out  out  1  key/tone on.
- busy  out  1  high in every state except IDLE.
- char_done  out  1  1-cycle pulse when a character finishes normally.
- err_unsupported  out  1  1-cycle pulse on lut_len == 0 or lut_len > 16.
- err_malformed  out  1  1-cycle pulse when the code ends in a lone 1.

Behaviour:
- Reset: all registers clear immediately, with no clock needed.
  - key_out = 0, char_ready = 0 during reset; char_ready = 1 in the first cycle after release.
  - lut_char = 0, busy = 0, all pulses 0, FSM = IDLE.
  - Reset mid-character aborts it with no pulse.
- FSM states: IDLE, LOAD, ON, OFF.
- IDLE: char_ready = 1.
  - Accept on char_valid && char_ready (cycle N): lut_char <= char_in, go to LOAD.
- LOAD (cycle N+1): char_ready = 0, key_out = 0.
  - Sample lut_code and lut_len.
  - If len == 0 or len > 16: pulse err_unsupported in cycle N+1, return to IDLE (ready again at N+2).
  - Otherwise: load shift register = lut_code << (16 - len), load bit counter = len, then parse the first element.
- Parse rule (combinational on shift-register MSBs and remaining count r; no bubble cycles):
  - MSB 0: dit. ON for 1 unit, consume 1 bit.
  - MSB 1, next bit 0, r ≥ 2: dah. ON for 3 units, consume 2 bits.
  - MSB 1, next bit 1, r ≥ 2: delimiter. Consume 2 bits, end of character.
  - MSB 1, r == 1: malformed. Pulse err_malformed, key_out low, go to IDLE.
  - r == 0 with no delimiter: end of character after the current OFF phase.
- ON: key_out = 1 for exactly units*UNIT_CYCLES cycles, then OFF.
- OFF length:
  - Base: 1 unit (intra-character gap).
  - If the next parse is a delimiter: 3 units total (letter gap), then end.
  - If r == 0: base 1 unit, then end.
- Space-only code (first parse is a delimiter, i.e. code 11, len 2): LOAD goes straight to OFF for 4 units with key low. Combined with the preceding letter gap this gives the 7-unit word gap.
- End of character: char_done pulses in the last OFF cycle, IDLE in the next cycle.
- First key_out high cycle for a character is N+2.
- Counter loads units*UNIT_CYCLES-1 and counts down to 0; the phase ends at 0.
- char_valid is ignored while char_ready = 0; char_in is not sampled.
- The error pulses and char_done are mutually exclusive.

Test Plan:
- UNIT_CYCLES=4, "E" (lut 011/3) accepted at N -> key_out high N+2..N+5, low N+6..N+17, char_done at N+17, char_ready at N+18.
- "A" (01011/5) at N -> high 4 cycles, low 4, high 12, low 12, char_done in the last low cycle; total 32 cycles after LOAD.
- "#" (len 0) at N -> err_unsupported at N+1, key_out never high, char_ready at N+2; lut_len=17 gives the same result.
- " " (11/2) at N -> key low N+2..N+17 (16 cycles), char_done at N+17, no error.
- Malformed lut_code=001/3 -> dit, dit, then err_malformed in the last cycle of the second OFF phase, no char_done.
- Hold char_valid with "T","E" back-to-back -> char_ready low throughout "T", "E" accepted the cycle ready rises.
- Reset mid-dah -> key_out 0 asynchronously; char_ready high the first cycle after release.
